// File: rtl/fifo_route_ctrl.sv
// fifo_route_ctrl
//   Arbiter and sequencer for the four-channel FIFO crossbar. The UART and SPI
//   hosts each request one of four channel FIFOs. One host at a time owns the
//   crossbar select. Its raw FIFO strobes only pass while it holds the grant.
//
//   Optional feature macro: ROUTE_TIMEOUT_EN. When it is defined, an owner
//   that issues no strobes for TIMEOUT cycles is forcibly released. That host
//   stays ineligible until its req has been seen low.
//
// Parameters
//   SETTLE_CYC  cycles upr is held stable before grant (1..15)
//   TIMEOUT     idle-owner cycles before forced release (2..65535)
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   uart_req, uart_ch              UART request level and requested channel
//   uart_gnt                       UART owns upr
//   uart_wr_in, uart_rd_in         raw UART strobes
//   uart_fifo_wr_en/rd_en          gated UART strobes
//   spi_req, spi_ch, spi_gnt       same roles for SPI
//   spi_wr_in, spi_clr_in          raw SPI strobes
//   fifo_wr_spi, spi_clr_fifo      gated SPI strobes
//   upr                            crossbar select (00-03 UART, 10-13 SPI, FF none)
//   busy                           controller not idle
//   drop_err                       sticky: raw strobe seen from an ungranted host
//   timeout_evt                    one-cycle pulse on forced release
module fifo_route_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_req,
  input  logic [1:0] uart_ch,
  output logic       uart_gnt,
  input  logic       uart_wr_in,
  input  logic       uart_rd_in,
  output logic       uart_fifo_wr_en,
  output logic       uart_fifo_rd_en,
  input  logic       spi_req,
  input  logic [1:0] spi_ch,
  output logic       spi_gnt,
  input  logic       spi_wr_in,
  input  logic       spi_clr_in,
  output logic       fifo_wr_spi,
  output logic       spi_clr_fifo,
  output logic [7:0] upr,
  output logic       busy,
  output logic       drop_err,
  output logic       timeout_evt
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be within 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be within 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [7:0] UPR_NONE  = 8'hFF;

  state_t     state;
  logic       owner;       // 0 = UART, 1 = SPI
  logic       rr;          // 0 favours UART when both request
  logic [3:0] settle_cnt;
  logic       uart_elig;
  logic       spi_elig;
  logic       pick_spi;
  logic       owner_req;
  logic       uart_raw;
  logic       spi_raw;

  assign uart_raw  = uart_wr_in | uart_rd_in;
  assign spi_raw   = spi_wr_in | spi_clr_in;
  assign owner_req = owner ? spi_req : uart_req;

`ifdef ROUTE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt;
  logic        uart_blk;
  logic        spi_blk;
  logic        owner_raw;

  assign owner_raw = owner ? spi_raw : uart_raw;
  assign uart_elig = uart_req & ~uart_blk;
  assign spi_elig  = spi_req & ~spi_blk;
`else
  assign uart_elig   = uart_req;
  assign spi_elig    = spi_req;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    pick_spi = spi_elig & (~uart_elig | rr);
  end

  // Gates use the registered grants, so a strobe only passes in GRANT.
  // Only the owner's grant is ever set, so the other host's strobes stay 0.
  assign uart_fifo_wr_en = uart_wr_in & uart_gnt;
  assign uart_fifo_rd_en = uart_rd_in & uart_gnt;
  assign fifo_wr_spi     = spi_wr_in & spi_gnt;
  assign spi_clr_fifo    = spi_clr_in & spi_gnt;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      rr         <= 1'b0;
      settle_cnt <= '0;
      upr        <= UPR_NONE;
      uart_gnt   <= 1'b0;
      spi_gnt    <= 1'b0;
      drop_err   <= 1'b0;
`ifdef ROUTE_TIMEOUT_EN
      to_cnt      <= '0;
      uart_blk    <= 1'b0;
      spi_blk     <= 1'b0;
      timeout_evt <= 1'b0;
`endif
    end else begin
      if ((uart_raw & ~uart_gnt) | (spi_raw & ~spi_gnt)) begin
        drop_err <= 1'b1;
      end
`ifdef ROUTE_TIMEOUT_EN
      timeout_evt <= 1'b0;
      // A block clears once req is sampled low. A timeout below re-sets it.
      uart_blk    <= uart_blk & uart_req;
      spi_blk     <= spi_blk & spi_req;
`endif
      case (state)
        S_IDLE: begin
          if (uart_elig | spi_elig) begin
            owner      <= pick_spi;
            upr        <= pick_spi ? {4'h1, 2'b00, spi_ch} : {6'b0, uart_ch};
            settle_cnt <= SETTLE_LD;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!owner_req) begin
            upr   <= UPR_NONE;
            state <= S_RELEASE;
          end else if (settle_cnt <= 4'd1) begin
            // The grant registers on the edge where the count would reach 0.
            // This keeps upr stable for exactly SETTLE_CYC cycles first.
            uart_gnt <= ~owner;
            spi_gnt  <= owner;
            state    <= S_GRANT;
`ifdef ROUTE_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_GRANT: begin
          if (!owner_req) begin
            uart_gnt <= 1'b0;
            spi_gnt  <= 1'b0;
            upr      <= UPR_NONE;
            state    <= S_RELEASE;
          end
`ifdef ROUTE_TIMEOUT_EN
          else if (owner_raw) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            uart_gnt    <= 1'b0;
            spi_gnt     <= 1'b0;
            upr         <= UPR_NONE;
            state       <= S_RELEASE;
            timeout_evt <= 1'b1;
            if (owner) spi_blk <= 1'b1;
            else       uart_blk <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        S_RELEASE: begin
          rr    <= ~owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_route_ctrl.sv
module tb_fifo_route_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_req, uart_wr_in, uart_rd_in;
  logic [1:0] uart_ch;
  logic       spi_req, spi_wr_in, spi_clr_in;
  logic [1:0] spi_ch;
  logic       uart_gnt, uart_fifo_wr_en, uart_fifo_rd_en;
  logic       spi_gnt, fifo_wr_spi, spi_clr_fifo;
  logic [7:0] upr;
  logic       busy, drop_err, timeout_evt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fifo_route_ctrl #(
    .SETTLE_CYC(2),
    .TIMEOUT   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_req       (uart_req),
    .uart_ch        (uart_ch),
    .uart_gnt       (uart_gnt),
    .uart_wr_in     (uart_wr_in),
    .uart_rd_in     (uart_rd_in),
    .uart_fifo_wr_en(uart_fifo_wr_en),
    .uart_fifo_rd_en(uart_fifo_rd_en),
    .spi_req        (spi_req),
    .spi_ch         (spi_ch),
    .spi_gnt        (spi_gnt),
    .spi_wr_in      (spi_wr_in),
    .spi_clr_in     (spi_clr_in),
    .fifo_wr_spi    (fifo_wr_spi),
    .spi_clr_fifo   (spi_clr_fifo),
    .upr            (upr),
    .busy           (busy),
    .drop_err       (drop_err),
    .timeout_evt    (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    uart_req = 0; uart_ch = 0; uart_wr_in = 0; uart_rd_in = 0;
    spi_req = 0;  spi_ch = 0;  spi_wr_in = 0;  spi_clr_in = 0;
    tick(2);
    check("rst_upr",   16'(upr), 16'h00FF);
    check("rst_gnt",   16'({uart_gnt, spi_gnt}), 16'h0);
    check("rst_busy",  16'(busy), 16'h0);
    check("rst_drop",  16'(drop_err), 16'h0);
    check("rst_to",    16'(timeout_evt), 16'h0);
    check("rst_strb",  16'({uart_fifo_wr_en, uart_fifo_rd_en, fifo_wr_spi, spi_clr_fifo}), 16'h0);
    rst = 1'b0;
    tick(1);

    // Single UART request on channel 2.
    uart_req = 1; uart_ch = 2;
    tick(1);
    check("single_upr",   16'(upr), 16'h0002);
    check("single_busy",  16'(busy), 16'h1);
    check("single_gnt0",  16'(uart_gnt), 16'h0);
    tick(1);
    check("single_gnt1",  16'(uart_gnt), 16'h0);
    tick(1);
    check("single_gnt2",  16'(uart_gnt), 16'h1);
    uart_wr_in = 1;
    #1;
    check("single_wr",    16'(uart_fifo_wr_en), 16'h1);
    check("single_spiwr", 16'(fifo_wr_spi), 16'h0);
    uart_wr_in = 0; uart_rd_in = 1;
    #1;
    check("single_rd",    16'(uart_fifo_rd_en), 16'h1);
    uart_rd_in = 0;
    uart_ch = 1;
    tick(1);
    check("ch_ignored",   16'(upr), 16'h0002);
    check("granted_drop", 16'(drop_err), 16'h0);
    uart_req = 0;
    tick(1);
    check("rel_upr",      16'(upr), 16'h00FF);
    check("rel_gnt",      16'(uart_gnt), 16'h0);
    check("rel_busy",     16'(busy), 16'h1);
    tick(1);
    check("rel_idle",     16'(busy), 16'h0);

    // Simultaneous requests after reset: UART first.
    do_reset();
    uart_req = 1; uart_ch = 0; spi_req = 1; spi_ch = 3;
    tick(1);
    check("both_upr",     16'(upr), 16'h0000);
    tick(2);
    check("both_gnt",     16'({uart_gnt, spi_gnt}), 16'h2);
    spi_wr_in = 1; spi_clr_in = 1;
    #1;
    check("ungr_wr",      16'({fifo_wr_spi, spi_clr_fifo}), 16'h0);
    tick(1);
    spi_wr_in = 0; spi_clr_in = 0;
    check("ungr_drop",    16'(drop_err), 16'h1);
    uart_req = 0;
    tick(1);
    // UART comes straight back. Round-robin must still favour SPI.
    uart_req = 1;
    check("hand_ff1",     16'(upr), 16'h00FF);
    tick(1);
    check("hand_ff2",     16'(upr), 16'h00FF);
    tick(1);
    check("hand_spi_upr", 16'(upr), 16'h0013);
    tick(2);
    check("hand_spi_gnt", 16'({uart_gnt, spi_gnt}), 16'h1);
    check("drop_sticky",  16'(drop_err), 16'h1);
    spi_wr_in = 1;
    #1;
    check("spi_wr",       16'(fifo_wr_spi), 16'h1);
    spi_wr_in = 0; spi_clr_in = 1;
    #1;
    check("spi_clr",      16'(spi_clr_fifo), 16'h1);
    spi_clr_in = 0;
    spi_req = 0;
    tick(3);
    check("back_uart",    16'(upr), 16'h0000);
    uart_req = 0;
    tick(3);
    check("back_idle",    16'({busy, upr}), 16'h00FF);

    // Abort during settle. A strobe during SETTLE is dropped.
    do_reset();
    check("drop_cleared", 16'(drop_err), 16'h0);
    uart_req = 1; uart_ch = 1;
    tick(1);
    check("abort_upr",    16'(upr), 16'h0001);
    uart_req = 0; uart_wr_in = 1;
    #1;
    check("settle_wr",    16'(uart_fifo_wr_en), 16'h0);
    tick(1);
    uart_wr_in = 0;
    check("abort_ff",     16'(upr), 16'h00FF);
    check("abort_gnt",    16'(uart_gnt), 16'h0);
    check("settle_drop",  16'(drop_err), 16'h1);
    tick(1);
    check("abort_busy",   16'(busy), 16'h0);
    check("abort_gnt2",   16'(uart_gnt), 16'h0);

`ifdef ROUTE_TIMEOUT_EN
    do_reset();
    spi_req = 1; spi_ch = 0;
    tick(1);
    check("to_upr",       16'(upr), 16'h0010);
    tick(2);
    check("to_gnt",       16'(spi_gnt), 16'h1);
    tick(7);
    check("to_pre_gnt",   16'(spi_gnt), 16'h1);
    check("to_pre_evt",   16'(timeout_evt), 16'h0);
    tick(1);
    check("to_evt",       16'(timeout_evt), 16'h1);
    check("to_gnt_off",   16'(spi_gnt), 16'h0);
    check("to_upr_ff",    16'(upr), 16'h00FF);
    tick(1);
    check("to_evt_pulse", 16'(timeout_evt), 16'h0);
    tick(3);
    check("to_blocked",   16'({busy, upr}), 16'h00FF);
    spi_req = 0;
    tick(1);
    spi_req = 1;
    tick(1);
    check("to_regrant",   16'(upr), 16'h0010);
    spi_req = 0;
    tick(3);
`else
    do_reset();
    spi_req = 1; spi_ch = 0;
    tick(3);
    check("hold_gnt",     16'(spi_gnt), 16'h1);
    tick(20);
    check("hold_gnt_late", 16'(spi_gnt), 16'h1);
    check("hold_no_evt",  16'(timeout_evt), 16'h0);
    spi_req = 0;
    tick(3);
`endif

    // Async reset while granted.
    uart_req = 1; uart_ch = 3;
    tick(3);
    check("ar_gnt",       16'({uart_gnt, upr}), 16'h0103);
    #2;
    rst = 1'b1;
    #1;
    check("ar_upr",       16'(upr), 16'h00FF);
    check("ar_gnt0",      16'({uart_gnt, spi_gnt}), 16'h0);
    check("ar_busy",      16'(busy), 16'h0);
    uart_req = 0;
    tick(1);
    rst = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
